// File: rtl/thread_pc_sequencer.sv
// thread_pc_sequencer: round-robin multithreaded PC sequencer for the fetch
// front-end. Every cycle one thread gets an issue slot. That thread either issues
// a fresh PC, re-issues its previous PC, follows a jump, or stays idle when it is
// disabled. Each thread's PC can also be reloaded at runtime through the restart
// port.
module thread_pc_sequencer #(
  parameter int PC_WIDTH           = 10,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int START_PC           = 0,
  parameter int START_PC_STRIDE    = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
  input  logic [THREAD_COUNT-1:0]       thread_enable,
  input  logic                          IO_ready,
  input  logic                          cancel,
  input  logic                          jump,
  input  logic [PC_WIDTH-1:0]           jump_destination,
  input  logic                          restart,
  input  logic [THREAD_COUNT_WIDTH-1:0] restart_thread,
  input  logic [PC_WIDTH-1:0]           restart_pc,
  output logic [PC_WIDTH-1:0]           pc,
  output logic [THREAD_COUNT_WIDTH-1:0] pc_thread,
  output logic                          pc_valid
);

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef logic [THREAD_COUNT_WIDTH-1:0] tid_t;

  // Reset PC of thread idx. The result is truncated, so it wraps modulo 2^PC_WIDTH.
  function automatic pc_t start_pc_of(input int unsigned idx);
    logic [63:0] sum;
    sum = 64'(START_PC) + 64'(idx) * 64'(START_PC_STRIDE);
    return sum[PC_WIDTH-1:0];
  endfunction

  localparam tid_t LAST_THREAD = tid_t'(THREAD_COUNT - 1);

  // Per-thread state.
  pc_t                     cur_pc_q  [THREAD_COUNT];
  pc_t                     cur_pc_d  [THREAD_COUNT];
  pc_t                     prev_pc_q [THREAD_COUNT];
  pc_t                     prev_pc_d [THREAD_COUNT];
  logic [THREAD_COUNT-1:0] primed_q, primed_d;

  // Slot pointer and registered issue outputs.
  tid_t current_thread_q, current_thread_d;
  pc_t  pc_q, pc_d;
  tid_t pc_thread_q, pc_thread_d;
  logic pc_valid_q, pc_valid_d;

  // Intermediate values for the issue decision.
  tid_t t;
  logic restart_hit;
  pc_t  issue_pc;
  logic issue_valid;

  // Round-robin slot pointer: 0 .. THREAD_COUNT-1, then back to 0.
  always_comb begin
    if (current_thread_q == LAST_THREAD) current_thread_d = '0;
    else                                 current_thread_d = current_thread_q + tid_t'(1);
  end

  // Issue decision for the current thread. After the decision, a restart
  // reload is applied on top, so it overrides any rule update to that thread.
  always_comb begin
    // NOTE: every combinational output gets a default first. Without that,
    // a branch that leaves one unassigned would infer a latch.
    cur_pc_d    = cur_pc_q;
    prev_pc_d   = prev_pc_q;
    primed_d    = primed_q;
    t           = current_thread_q;
    issue_pc    = cur_pc_q[t];
    issue_valid = 1'b0;
    restart_hit = restart && (32'(restart_thread) < 32'(THREAD_COUNT));

    if (!thread_enable[t]) begin
      // Disabled thread: report its held PC as a bubble and change no state.
      issue_valid = 1'b0;
    end else if (!primed_q[t]) begin
      // First issue since reset. Feedback belongs to no instruction of this thread.
      issue_valid  = 1'b1;
      prev_pc_d[t] = cur_pc_q[t];
      cur_pc_d[t]  = cur_pc_q[t] + pc_t'(1);
      primed_d[t]  = 1'b1;
    end else if (!IO_ready && !cancel) begin
      // The previous instruction stalled on IO, so issue it again.
      issue_pc    = prev_pc_q[t];
      issue_valid = 1'b1;
    end else if (jump) begin
      issue_pc     = jump_destination;
      issue_valid  = 1'b1;
      prev_pc_d[t] = jump_destination;
      cur_pc_d[t]  = jump_destination + pc_t'(1);
    end else begin
      issue_valid  = 1'b1;
      prev_pc_d[t] = cur_pc_q[t];
      cur_pc_d[t]  = cur_pc_q[t] + pc_t'(1);
    end

    if (restart_hit) begin
      cur_pc_d[restart_thread]  = restart_pc;
      prev_pc_d[restart_thread] = restart_pc;
      primed_d[restart_thread]  = 1'b1;
      // A restart of the thread in the current slot annuls that slot's issue.
      if (restart_thread == t) issue_valid = 1'b0;
    end

    pc_d        = issue_pc;
    pc_thread_d = t;
    pc_valid_d  = issue_valid;
  end

  // All state, including the per-thread PC arrays, with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the PC arrays are reset explicitly, one entry per thread, so no
      // init file or preload is needed. This works only because they are flops,
      // not a RAM macro.
      for (int i = 0; i < THREAD_COUNT; i++) begin
        cur_pc_q[i]  <= start_pc_of(i);
        prev_pc_q[i] <= start_pc_of(i);
      end
      primed_q         <= '0;
      current_thread_q <= '0;
      pc_q             <= '0;
      pc_thread_q      <= '0;
      pc_valid_q       <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignment. Every flop then
      // samples its pre-edge value, independent of statement order.
      cur_pc_q         <= cur_pc_d;
      prev_pc_q        <= prev_pc_d;
      primed_q         <= primed_d;
      current_thread_q <= current_thread_d;
      pc_q             <= pc_d;
      pc_thread_q      <= pc_thread_d;
      pc_valid_q       <= pc_valid_d;
    end
  end

  assign current_thread = current_thread_q;
  assign pc             = pc_q;
  assign pc_thread      = pc_thread_q;
  assign pc_valid       = pc_valid_q;

endmodule
